operand_buffer: RTL and testbench
=================================

OPERAND_BUFFER -- requirements
Module: operand_buffer

Interface
REQ-001: Parameters: none; the widths are fixed at 8-bit data, 3-bit address and 2-bit selects.
REQ-002: clk  input  1  single clock; all state updates on the rising edge.
REQ-003: rst_n  input  1  asynchronous, active-low reset.
REQ-004: load_en  input  1  host byte-write strobe, one byte per cycle.
REQ-005: mem_addr  input  3  write address; 0-3 = weights W0..W3 (row-major A), 4-7 = inputs X0..X3 (row-major B).
REQ-006: in_data  input  8  host write byte, two's complement.
REQ-007: transpose  input  1  use B transposed; sampled at bank swap only.
REQ-008: a0_sel, a1_sel, b0_sel, b1_sel  input  2 each  operand selects from the control unit.
REQ-009: a0, a1, b0, b1  output  8 each  signed registered operands to the systolic array.
REQ-010: bank_valid  output  1  high once the first complete bank has been swapped in.
REQ-011: swap_pulse  output  1  one-cycle pulse on the cycle after a swap.
REQ-012: partial_err  output  1  sticky flag; set when a swap occurs with an incomplete fill bank.

Function
REQ-013: Storage SHALL be two banks of 8 bytes each: a fill bank and an active bank, identified by a 1-bit pointer act_ptr.
REQ-014: With load_en=1, in_data SHALL be written to fill bank[mem_addr], and bit mem_addr of an 8-bit fill_mask SHALL be set.
REQ-015: A write to address 7 SHALL trigger a swap at that same edge: byte 7 is written, act_ptr toggles, transpose is latched into t_lat, and fill_mask clears to 0.
REQ-016: If fill_mask (including bit 7) is not all ones at a swap, the swap SHALL still occur and partial_err SHALL set; partial_err clears only on reset.
REQ-017: Rewriting an address before a swap SHALL overwrite it with last-write-wins; fill_mask stays set.
REQ-018: Writes SHALL never modify the active bank.
REQ-019: Writes to addresses 0-6 SHALL NOT swap banks.
REQ-020: State machine SHALL have two states:
  - EMPTY (reset state) -> LOADED on the first swap.
  - LOADED stays LOADED until reset.
  - bank_valid = (state == LOADED).
REQ-021: Operand muxes SHALL read only the active bank; outputs register one cycle after the selects are presented (latency 1).
REQ-022: a0 SHALL be sel 0 -> W0, 1 -> W1, 2 or 3 -> 0.
REQ-023: a1 SHALL be sel 0 -> W2, 1 -> W3, 2 or 3 -> 0.
REQ-024: b0 SHALL be sel 0 -> X0, 1 -> (t_lat ? X1 : X2), 2 or 3 -> 0.
REQ-025: b1 SHALL be sel 0 -> (t_lat ? X2 : X1), 1 -> X3, 2 or 3 -> 0.
REQ-026: In state EMPTY, all operand outputs SHALL be 0 regardless of the selects.
REQ-027: On the edge of a swap, the operand registers SHALL load from the pre-swap active bank; the new bank is visible from the following edge.
REQ-028: swap_pulse SHALL be high for exactly one cycle after each swap.
REQ-029: On back-to-back swaps (address 7 written on consecutive cycles), each write SHALL produce one swap and one swap_pulse.
REQ-030: A change on transpose between swaps SHALL NOT affect the outputs.

Reset
REQ-031: While rst_n=0, regardless of clk, the block SHALL hold:
  - both banks, fill_mask, act_ptr, t_lat = 0;
  - state = EMPTY;
  - a0, a1, b0, b1 = 0;
  - bank_valid, swap_pulse, partial_err = 0.
REQ-032: A reset asserted mid-fill SHALL discard the partial bank; the next fill starts from an empty mask.
REQ-033: Reset release SHALL be synchronised by the integrator; this block only requires rst_n deassertion to be clean relative to clk.

Verification
REQ-034: Write bytes 1,2,3,4,5,6,7,8 to addresses 0-7 with transpose=0, then sels (a0,a1,b0,b1) = (0,2,0,2), (1,0,1,0), (2,1,2,1):
  - expected (1,0,5,0), (2,3,7,6), (0,4,0,8);
  - bank_valid=1; partial_err=0.
REQ-035: Same data with transpose=1 at the address-7 write: sel 1 on b0 -> 6; sel 0 on b1 -> 7; then toggle transpose with no new load -> outputs unchanged.
REQ-036: Load bank A (1..8), then bank B (0x11..0x18) while holding sel a0=0:
  - a0 = 1 through the swap edge;
  - a0 = 0x11 on the following cycle;
  - swap_pulse high exactly one cycle.
REQ-037: Write only addresses 5,6,7 from reset -> swap occurs, partial_err=1, a0 with sel 0 = 0.
REQ-038: Assert rst_n=0 asynchronously mid-fill after a loaded bank:
  - all outputs 0 immediately, without a clock edge;
  - after release, bank_valid=0 and operands = 0 for any sel.
REQ-039: Negative data: W0=0x80, X0=0xFF, sel 0 -> a0=-128, b0=-1.

Source files
------------

// File: rtl/operand_buffer_if.sv
// operand_buffer_if: host load port, operand selects and systolic operand outputs of operand_buffer.
interface operand_buffer_if;
   logic              load_en;
   logic [2:0]        mem_addr;
   logic [7:0]        in_data;
   logic              transpose;
   logic [1:0]        a0_sel, a1_sel, b0_sel, b1_sel;
   logic signed [7:0] a0, a1, b0, b1;
   logic              bank_valid, swap_pulse, partial_err;
   modport master (
      output load_en, mem_addr, in_data, transpose, a0_sel, a1_sel, b0_sel, b1_sel,
      input  a0, a1, b0, b1, bank_valid, swap_pulse, partial_err
   );
   modport slave (
      input  load_en, mem_addr, in_data, transpose, a0_sel, a1_sel, b0_sel, b1_sel,
      output a0, a1, b0, b1, bank_valid, swap_pulse, partial_err
   );
endinterface

// File: rtl/operand_buffer.sv
// operand_buffer: double-buffered 2x2 weight/input store feeding registered operands to a systolic array.
module operand_buffer (
   input logic             clk,
   input logic             rst_n,
   operand_buffer_if.slave bus
);
   localparam logic [0:0] EMPTY  = 1'b0;
   localparam logic [0:0] LOADED = 1'b1;
   logic [1:0][7:0][7:0] bank_q, bank_d;
   logic [7:0]           fill_mask_q, fill_mask_d;
   logic                 act_ptr_q, act_ptr_d;
   logic                 t_lat_q, t_lat_d;
   logic [0:0]           state_q, state_d;
   logic                 swap_pulse_q, swap_pulse_d;
   logic                 partial_err_q, partial_err_d;
   logic [7:0]           a0_q, a0_d, a1_q, a1_d, b0_q, b0_d, b1_q, b1_d;
   logic [7:0][7:0]      act;
   logic                 swap, loaded;
   function automatic logic [7:0] pick(input logic [1:0] sel, input logic [7:0] v0, input logic [7:0] v1);
      return sel == 2'd0 ? v0 : sel == 2'd1 ? v1 : 8'd0;
   endfunction
   always_comb begin
      swap          = bus.load_en && bus.mem_addr == 3'd7;
      loaded        = state_q == LOADED;
      act           = bank_q[act_ptr_q];
      bank_d        = bank_q;
      fill_mask_d   = fill_mask_q;
      act_ptr_d     = act_ptr_q;
      t_lat_d       = t_lat_q;
      state_d       = state_q;
      partial_err_d = partial_err_q;
      swap_pulse_d  = swap;
      if (bus.load_en) begin
         bank_d[~act_ptr_q][bus.mem_addr] = bus.in_data;
         fill_mask_d[bus.mem_addr]        = 1'b1;
      end
      // bit 7 is being written on this very edge, so only bits 0-6 can be missing
      if (swap) begin
         act_ptr_d     = ~act_ptr_q;
         t_lat_d       = bus.transpose;
         fill_mask_d   = 8'h00;
         state_d       = LOADED;
         partial_err_d = partial_err_q | ~&(fill_mask_q | 8'h80);
      end
      a0_d = loaded ? pick(bus.a0_sel, act[0], act[1]) : 8'd0;
      a1_d = loaded ? pick(bus.a1_sel, act[2], act[3]) : 8'd0;
      b0_d = loaded ? pick(bus.b0_sel, act[4], t_lat_q ? act[5] : act[6]) : 8'd0;
      b1_d = loaded ? pick(bus.b1_sel, t_lat_q ? act[6] : act[5], act[7]) : 8'd0;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_q        <= '0;
         fill_mask_q   <= '0;
         act_ptr_q     <= 1'b0;
         t_lat_q       <= 1'b0;
         state_q       <= EMPTY;
         swap_pulse_q  <= 1'b0;
         partial_err_q <= 1'b0;
         a0_q          <= '0;
         a1_q          <= '0;
         b0_q          <= '0;
         b1_q          <= '0;
      end else begin
         bank_q        <= bank_d;
         fill_mask_q   <= fill_mask_d;
         act_ptr_q     <= act_ptr_d;
         t_lat_q       <= t_lat_d;
         state_q       <= state_d;
         swap_pulse_q  <= swap_pulse_d;
         partial_err_q <= partial_err_d;
         a0_q          <= a0_d;
         a1_q          <= a1_d;
         b0_q          <= b0_d;
         b1_q          <= b1_d;
      end
   end
   assign bus.a0          = a0_q;
   assign bus.a1          = a1_q;
   assign bus.b0          = b0_q;
   assign bus.b1          = b1_q;
   assign bus.bank_valid  = state_q == LOADED;
   assign bus.swap_pulse  = swap_pulse_q;
   assign bus.partial_err = partial_err_q;
endmodule

// File: tb/tb_operand_buffer.sv
// tb_operand_buffer: scoreboard bench for operand_buffer against a behavioural bank model.
module tb_operand_buffer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   operand_buffer_if bus();
   operand_buffer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   int n_chk = 0;
   int n_err = 0;
   logic [31:0] sb[$];
   logic [7:0] m_bank[2][8];
   logic [7:0] m_mask;
   logic m_act, m_tlat, m_loaded, m_swap, m_perr;
   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic m_reset();
      for (int b = 0; b < 2; b++) for (int i = 0; i < 8; i++) m_bank[b][i] = 8'h00;
      m_mask = 8'h00;
      {m_act, m_tlat, m_loaded, m_swap, m_perr} = 5'b0;
   endtask
   function automatic logic [7:0] m_op(input int k, input logic [1:0] s);
      logic [7:0] w[4];
      logic [7:0] x[4];
      if (!m_loaded || s[1]) return 8'h00;
      for (int i = 0; i < 4; i++) begin
         w[i] = m_bank[m_act][i];
         x[i] = m_bank[m_act][4+i];
      end
      case (k)
         0: return s[0] ? w[1] : w[0];
         1: return s[0] ? w[3] : w[2];
         2: return s[0] ? (m_tlat ? x[1] : x[2]) : x[0];
         default: return s[0] ? x[3] : (m_tlat ? x[2] : x[1]);
      endcase
   endfunction
   task automatic m_write(input logic le, input logic [2:0] ad, input logic [7:0] d, input logic t);
      m_swap = le && ad == 3'd7;
      if (!le) return;
      m_bank[!m_act][ad] = d;
      m_mask[ad] = 1'b1;
      if (m_swap) begin
         if (m_mask != 8'hFF) m_perr = 1'b1;
         m_act = !m_act;
         m_tlat = t;
         m_mask = 8'h00;
         m_loaded = 1'b1;
      end
   endtask
   task automatic step(input logic le, input logic [2:0] ad, input logic [7:0] d, input logic t,
                       input logic [1:0] s0, input logic [1:0] s1, input logic [1:0] s2, input logic [1:0] s3);
      logic [31:0] e;
      bus.load_en = le;
      bus.mem_addr = ad;
      bus.in_data = d;
      bus.transpose = t;
      bus.a0_sel = s0;
      bus.a1_sel = s1;
      bus.b0_sel = s2;
      bus.b1_sel = s3;
      sb.push_back({m_op(0, s0), m_op(1, s1), m_op(2, s2), m_op(3, s3)});
      m_write(le, ad, d, t);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("a0", bus.a0, e[31:24]);
      chk("a1", bus.a1, e[23:16]);
      chk("b0", bus.b0, e[15:8]);
      chk("b1", bus.b1, e[7:0]);
      chk("bank_valid", {7'd0, bus.bank_valid}, {7'd0, m_loaded});
      chk("swap_pulse", {7'd0, bus.swap_pulse}, {7'd0, m_swap});
      chk("partial_err", {7'd0, bus.partial_err}, {7'd0, m_perr});
      bus.load_en = 1'b0;
   endtask
   task automatic load8(input logic [7:0] base, input logic t);
      for (int i = 0; i < 8; i++) step(1'b1, 3'(i), base + 8'(i), t, 2'd0, 2'd0, 2'd0, 2'd0);
   endtask
   task automatic chk_zero(input string tag);
      chk({tag, "_a0"}, bus.a0, 8'h00);
      chk({tag, "_a1"}, bus.a1, 8'h00);
      chk({tag, "_b0"}, bus.b0, 8'h00);
      chk({tag, "_b1"}, bus.b1, 8'h00);
      chk({tag, "_flags"}, {5'd0, bus.bank_valid, bus.swap_pulse, bus.partial_err}, 8'h00);
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      m_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask
   initial begin
      bus.load_en = 1'b0;
      bus.mem_addr = '0;
      bus.in_data = '0;
      bus.transpose = 1'b0;
      {bus.a0_sel, bus.a1_sel, bus.b0_sel, bus.b1_sel} = '0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      load8(8'd1, 1'b0);
      step(1'b0, 3'd0, 8'd0, 1'b0, 2'd0, 2'd2, 2'd0, 2'd2);
      chk("s1_a0", bus.a0, 8'd1); chk("s1_a1", bus.a1, 8'd0); chk("s1_b0", bus.b0, 8'd5); chk("s1_b1", bus.b1, 8'd0);
      step(1'b0, 3'd0, 8'd0, 1'b0, 2'd1, 2'd0, 2'd1, 2'd0);
      chk("s2_a0", bus.a0, 8'd2); chk("s2_a1", bus.a1, 8'd3); chk("s2_b0", bus.b0, 8'd7); chk("s2_b1", bus.b1, 8'd6);
      step(1'b0, 3'd0, 8'd0, 1'b0, 2'd2, 2'd1, 2'd2, 2'd1);
      chk("s3_a0", bus.a0, 8'd0); chk("s3_a1", bus.a1, 8'd4); chk("s3_b0", bus.b0, 8'd0); chk("s3_b1", bus.b1, 8'd8);
      chk("s3_valid", {7'd0, bus.bank_valid}, 8'd1);
      chk("s3_perr", {7'd0, bus.partial_err}, 8'd0);
      load8(8'd1, 1'b1);
      step(1'b0, 3'd0, 8'd0, 1'b1, 2'd0, 2'd0, 2'd1, 2'd0);
      chk("tr_b0", bus.b0, 8'd6); chk("tr_b1", bus.b1, 8'd7);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 3'd0, 8'd0, 1'(i), 2'd0, 2'd0, 2'd1, 2'd0);
         chk("tr_hold_b0", bus.b0, 8'd6); chk("tr_hold_b1", bus.b1, 8'd7);
      end
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 3'(i), 8'h11 + 8'(i), 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
         chk("swap_old_a0", bus.a0, 8'd1);
      end
      chk("swap_pulse_hi", {7'd0, bus.swap_pulse}, 8'd1);
      step(1'b0, 3'd0, 8'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
      chk("swap_new_a0", bus.a0, 8'h11);
      chk("swap_pulse_lo", {7'd0, bus.swap_pulse}, 8'd0);
      step(1'b1, 3'd0, 8'h55, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
      step(1'b1, 3'd1, 8'h66, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
      #2;
      rst_n = 1'b0;
      m_reset();
      #1;
      chk_zero("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      for (int s = 0; s < 4; s++) begin
         step(1'b0, 3'd0, 8'd0, 1'b0, 2'(s), 2'(s), 2'(s), 2'(s));
         chk_zero("post_rst");
      end
      step(1'b1, 3'd5, 8'h21, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
      step(1'b1, 3'd6, 8'h22, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
      step(1'b1, 3'd7, 8'h23, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
      step(1'b0, 3'd0, 8'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
      chk("partial_a0", bus.a0, 8'h00);
      chk("partial_err", {7'd0, bus.partial_err}, 8'd1);
      step(1'b1, 3'd7, 8'h31, 1'b0, 2'd0, 2'd0, 2'd0, 2'd1);
      chk("b2b_pulse1", {7'd0, bus.swap_pulse}, 8'd1);
      step(1'b1, 3'd7, 8'h32, 1'b0, 2'd0, 2'd0, 2'd0, 2'd1);
      chk("b2b_pulse2", {7'd0, bus.swap_pulse}, 8'd1);
      step(1'b0, 3'd0, 8'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd1);
      chk("b2b_b1", bus.b1, 8'h32);
      chk("b2b_pulse_lo", {7'd0, bus.swap_pulse}, 8'd0);
      do_reset();
      step(1'b1, 3'd0, 8'h80, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
      for (int i = 1; i < 4; i++) step(1'b1, 3'(i), 8'h00, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
      step(1'b1, 3'd4, 8'hFF, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
      for (int i = 5; i < 8; i++) step(1'b1, 3'(i), 8'h00, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
      step(1'b0, 3'd0, 8'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
      chk("neg_a0", bus.a0, 8'h80);
      chk("neg_b0", bus.b0, 8'hFF);
      chk("neg_sign", {7'd0, bus.a0 < 0 && bus.b0 == -8'sd1}, 8'd1);
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom),
              2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
